// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl shared definitions: step FSM encoding, cycle constants
// and the counter width helper used by every counter in the block.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } step_state_e;

    // Board timing at 100 MHz
    localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int unsigned DEF_HOLD_CYC     = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYC   = 10_000_000;
    localparam int unsigned DEF_TICK_CYC     = 100_000_000;

    // Short timing for simulation
    localparam int unsigned SIM_DEBOUNCE_CYC = 4;
    localparam int unsigned SIM_HOLD_CYC     = 20;
    localparam int unsigned SIM_REPEAT_CYC   = 5;
    localparam int unsigned SIM_TICK_CYC     = 8;

    // Counter width able to hold the value p itself
    function automatic int unsigned cnt_w(input int unsigned p);
        return (p <= 1) ? 1 : $clog2(p) + 1;
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Key and strobe bundle between the board keys and counter_ctrl.
// master = board/datapath side, slave = counter_ctrl.
interface counter_ctrl_if;

    logic [1:0] key_i;
    logic       inc_o;
    logic       run_o;
    logic [1:0] state_o;

    modport master (
        output key_i,
        input  inc_o,
        input  run_o,
        input  state_o
    );

    modport slave (
        input  key_i,
        output inc_o,
        output run_o,
        output state_o
    );

endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, debounce counter, press pulse.
// Level is 1 while the (active-low) key is held; press_o is one cycle.
module key_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYC);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // Count while synced level disagrees; flip after DEBOUNCE_CYC cycles
    always_comb begin
        sync_d  = {sync_q[0], ~key_n_i};
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC)) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers, synchronous reset to released
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Increment strobe sequencer: step, hold-to-repeat and run mode.
// Hold/repeat is built only with COUNTER_CTRL_AUTOREPEAT_EN defined.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int unsigned TICK_CYC     = DEF_TICK_CYC
) (
    input  logic          clk100_i,
    input  logic          rst_i,
    counter_ctrl_if.slave bus
);

    localparam int unsigned TW = cnt_w(TICK_CYC);

    logic step_lvl, step_press;
    logic run_lvl, run_press;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .key_n_i  (bus.key_i[0]),
        .level_o  (step_lvl),
        .press_o  (step_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .key_n_i  (bus.key_i[1]),
        .level_o  (run_lvl),
        .press_o  (run_press)
    );

    logic          run_q, run_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          inc_q, inc_d;

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
    localparam int unsigned HW = cnt_w(HOLD_CYC);
    localparam int unsigned RW = cnt_w(REPEAT_CYC);
    localparam int unsigned PW = (HW > RW) ? HW : RW;

    step_state_e   state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
`endif

    // Run toggle wins over step; run ticks; step FSM only when stopped
    always_comb begin
        run_d  = run_q;
        tick_d = tick_q;
        inc_d  = 1'b0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
        state_d = state_q;
        ph_d    = ph_q;
`endif
        if (run_press) begin
            run_d  = ~run_q;
            tick_d = '0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
            state_d = IDLE;
            ph_d    = '0;
`endif
        end else if (run_q) begin
            if (tick_q == TW'(TICK_CYC - 1)) begin
                tick_d = '0;
                inc_d  = 1'b1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end else begin
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
            unique case (state_q)
                IDLE: begin
                    if (step_press) begin
                        inc_d   = 1'b1;
                        state_d = HOLD;
                        ph_d    = '0;
                    end
                end
                HOLD: begin
                    if (!step_lvl) begin
                        state_d = IDLE;
                    end else if (ph_q == PW'(HOLD_CYC - 1)) begin
                        inc_d   = 1'b1;
                        state_d = REPEAT;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + PW'(1);
                    end
                end
                REPEAT: begin
                    if (!step_lvl) begin
                        state_d = IDLE;
                    end else if (ph_q == PW'(REPEAT_CYC - 1)) begin
                        inc_d = 1'b1;
                        ph_d  = '0;
                    end else begin
                        ph_d = ph_q + PW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
`else
            inc_d = step_press;
`endif
        end
    end

    // Registered controller state and outputs
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            run_q  <= 1'b0;
            tick_q <= '0;
            inc_q  <= 1'b0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
            state_q <= IDLE;
            ph_q    <= '0;
`endif
        end else begin
            run_q  <= run_d;
            tick_q <= tick_d;
            inc_q  <= inc_d;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
            state_q <= state_d;
            ph_q    <= ph_d;
`endif
        end
    end

    assign bus.inc_o = inc_q;
    assign bus.run_o = run_q;

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
    assign bus.state_o = state_q;

    logic unused_lvl;
    assign unused_lvl = run_lvl;
`else
    assign bus.state_o = 2'b00;

    logic unused_cfg;
    assign unused_cfg = ^{HOLD_CYC, REPEAT_CYC, step_lvl, run_lvl};
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl at simulation timing: vector table with a
// strobe scoreboard plus hand-written run-entry and reset sequences.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    counter_ctrl_if bus_if();

    counter_ctrl #(
        .DEBOUNCE_CYC (SIM_DEBOUNCE_CYC),
        .HOLD_CYC     (SIM_HOLD_CYC),
        .REPEAT_CYC   (SIM_REPEAT_CYC),
        .TICK_CYC     (SIM_TICK_CYC)
    ) dut (
        .clk100_i (clk),
        .rst_i    (rst),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // k*_s/k*_n: first edge and length of a low window (n=0: none)
    // strobes: s0, s0+gap, then every per, cnt strobes in total
    typedef struct packed {
        int k0_s;
        int k0_n;
        int k1_s;
        int k1_n;
        int k1b_s;
        int k1b_n;
        int ncyc;
        int s0;
        int gap;
        int per;
        int cnt;
        int exp_run;
        int exp_state;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.key_i = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit in_win(input int e, input int s, input int n);
        return (n > 0) && (e >= s) && (e < s + n);
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int q[$];
        int exp_e;
        do_reset();
        for (int i = 0; i < v.cnt; i++) begin
            if (i == 0)
                q.push_back(v.s0);
            else if (i == 1)
                q.push_back(v.s0 + v.gap);
            else
                q.push_back(v.s0 + v.gap + (i - 1) * v.per);
        end
        for (int e = 0; e < v.ncyc; e++) begin
            @(negedge clk);
            bus_if.key_i[0] = !in_win(e, v.k0_s, v.k0_n);
            bus_if.key_i[1] = !(in_win(e, v.k1_s, v.k1_n)
                             || in_win(e, v.k1b_s, v.k1b_n));
            @(posedge clk);
            #1;
            if (bus_if.inc_o) begin
                checks++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL vec%0d strobe: got edge %0d, expected none",
                             id, e);
                end else begin
                    exp_e = q.pop_front();
                    if (exp_e != e) begin
                        errs++;
                        $display("FAIL vec%0d strobe: got edge %0d, expected %0d",
                                 id, e, exp_e);
                    end
                end
            end
        end
        chk($sformatf("vec%0d missed strobes", id), q.size(), 0);
        chk($sformatf("vec%0d run_o", id), int'(bus_if.run_o), v.exp_run);
        chk($sformatf("vec%0d state_o", id), int'(bus_if.state_o), v.exp_state);
    endtask

    initial begin
        bit saw_early;

        bus_if.key_i = 2'b11;

        vecs[0] = '{k0_s:0, k0_n:10, k1_s:0, k1_n:0, k1b_s:0, k1b_n:0,
                    ncyc:30, s0:7, gap:0, per:0, cnt:1,
                    exp_run:0, exp_state:0};
        vecs[1] = '{k0_s:0, k0_n:3, k1_s:0, k1_n:0, k1b_s:0, k1b_n:0,
                    ncyc:20, s0:0, gap:0, per:0, cnt:0,
                    exp_run:0, exp_state:0};
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
        vecs[2] = '{k0_s:0, k0_n:60, k1_s:0, k1_n:0, k1b_s:0, k1b_n:0,
                    ncyc:80, s0:7, gap:20, per:5, cnt:9,
                    exp_run:0, exp_state:0};
`else
        vecs[2] = '{k0_s:0, k0_n:60, k1_s:0, k1_n:0, k1b_s:0, k1b_n:0,
                    ncyc:80, s0:7, gap:0, per:0, cnt:1,
                    exp_run:0, exp_state:0};
`endif
        vecs[3] = '{k0_s:0, k0_n:0, k1_s:0, k1_n:10, k1b_s:32, k1b_n:10,
                    ncyc:60, s0:15, gap:8, per:8, cnt:3,
                    exp_run:0, exp_state:0};
        vecs[4] = '{k0_s:0, k0_n:10, k1_s:0, k1_n:10, k1b_s:0, k1b_n:0,
                    ncyc:30, s0:15, gap:8, per:8, cnt:2,
                    exp_run:1, exp_state:0};
        vecs[5] = '{k0_s:20, k0_n:10, k1_s:0, k1_n:10, k1b_s:0, k1b_n:0,
                    ncyc:40, s0:15, gap:8, per:8, cnt:4,
                    exp_run:1, exp_state:0};

        // Reset state
        do_reset();
        @(posedge clk);
        #1;
        chk("reset inc_o", int'(bus_if.inc_o), 0);
        chk("reset run_o", int'(bus_if.run_o), 0);
        chk("reset state_o", int'(bus_if.state_o), 0);

        for (int i = 0; i < 6; i++)
            run_vec(i, vecs[i]);

        // Reset while in run mode drops run_o
        do_reset();
        @(posedge clk);
        #1;
        chk("reset after run run_o", int'(bus_if.run_o), 0);

        // Run entry lands exactly on edge 7
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            bus_if.key_i = 2'b01;
            @(posedge clk);
            #1;
            if (e == 6)
                chk("run_o before edge 7", int'(bus_if.run_o), 0);
            if (e == 7)
                chk("run_o at edge 7", int'(bus_if.run_o), 1);
        end

        // One-cycle reset during REPEAT with step still held
        do_reset();
        saw_early = 1'b0;
        for (int e = 0; e < 45; e++) begin
            @(negedge clk);
            bus_if.key_i = 2'b10;
            rst = (e == 34);
            @(posedge clk);
            #1;
            if (e == 33) begin
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
                chk("pre-reset state_o", int'(bus_if.state_o), 2);
`else
                chk("pre-reset state_o", int'(bus_if.state_o), 0);
`endif
            end
            if (e == 34) begin
                chk("mid reset inc_o", int'(bus_if.inc_o), 0);
                chk("mid reset state_o", int'(bus_if.state_o), 0);
                chk("mid reset run_o", int'(bus_if.run_o), 0);
            end
            if (e >= 35 && e <= 41 && bus_if.inc_o)
                saw_early = 1'b1;
            if (e == 42)
                chk("post-reset first strobe", int'(bus_if.inc_o), 1);
        end
        chk("post-reset early strobe", int'(saw_early), 0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.key_i = 2'b11;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
